// File: rtl/dcache_direct_mapped.sv
// Direct-mapped, write-through, write-allocate data cache with an integrated backing word memory.
// Define DCACHE_STATS_EN to add saturating read hit/miss counters (hit_count, miss_count).
module dcache_direct_mapped #(
   parameter int unsigned TAG_W    = 3,
   parameter int unsigned INDEX_W  = 10,
   parameter int unsigned OFFSET_W = 4,
   parameter int unsigned DATA_W   = 32
) (
   input  logic                              clk,
   input  logic                              rst,
   input  logic [TAG_W+INDEX_W+OFFSET_W-1:0] r_addr,
   input  logic [TAG_W+INDEX_W+OFFSET_W-1:0] w_addr,
   input  logic [DATA_W-1:0]                 w_data,
   input  logic                              r_enable,
   input  logic                              w_enable,
   output logic [DATA_W-1:0]                 r_data
`ifdef DCACHE_STATS_EN
   ,
   output logic [15:0]                       hit_count,
   output logic [15:0]                       miss_count
`endif
);

   localparam int unsigned ADDR_W = TAG_W + INDEX_W + OFFSET_W;
   localparam int unsigned LINES  = 1 << INDEX_W;
   localparam int unsigned WORDS  = 1 << OFFSET_W;
   localparam int unsigned DEPTH  = 1 << ADDR_W;

   logic [LINES-1:0]  valid_q;
   logic [TAG_W-1:0]  tag_q  [LINES];
   logic [DATA_W-1:0] data_q [LINES][WORDS];
   logic [DATA_W-1:0] mem_q  [DEPTH];

   logic [TAG_W-1:0]    r_tag,  w_tag;
   logic [INDEX_W-1:0]  r_idx,  w_idx;
   logic [OFFSET_W-1:0] r_off,  w_off;
   logic                r_hit,  w_hit;
   logic                same_addr, same_idx, r_fill;
   logic [DATA_W-1:0]   rd_word;

   assign {r_tag, r_idx, r_off} = r_addr;
   assign {w_tag, w_idx, w_off} = w_addr;

   assign r_hit     = valid_q[r_idx] && (tag_q[r_idx] == r_tag);
   assign w_hit     = valid_q[w_idx] && (tag_q[w_idx] == w_tag);
   assign same_addr = w_enable && (r_addr == w_addr);
   // A concurrent write owns the line at its index; the read then must not allocate.
   assign same_idx  = w_enable && (r_idx == w_idx);
   assign r_fill    = r_enable && !r_hit && !same_idx;

   // Lines are always coherent with memory, so a miss can return the backing word directly.
   always_comb begin
      rd_word = mem_q[r_addr];
      if (same_addr) begin
         rd_word = w_data;
      end else if (r_hit) begin
         rd_word = data_q[r_idx][r_off];
      end
   end

   // Control state: valid bits, read data register, optional counters.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         valid_q <= '0;
         r_data  <= '0;
      end else begin
         if (w_enable) begin
            valid_q[w_idx] <= 1'b1;
         end
         if (r_fill) begin
            valid_q[r_idx] <= 1'b1;
         end
         if (r_enable) begin
            r_data <= rd_word;
         end
      end
   end

   // Tag/data arrays and backing memory are never cleared; a reset only suppresses updates.
   always_ff @(posedge clk or posedge rst) begin
      if (!rst) begin
         if (w_enable) begin
            mem_q[w_addr] <= w_data;
            if (w_hit) begin
               data_q[w_idx][w_off] <= w_data;
            end else begin
               tag_q[w_idx] <= w_tag;
               for (int i = 0; i < WORDS; i++) begin
                  data_q[w_idx][OFFSET_W'(i)] <= (OFFSET_W'(i) == w_off) ? w_data
                                               : mem_q[{w_tag, w_idx, OFFSET_W'(i)}];
               end
            end
         end
         if (r_fill) begin
            tag_q[r_idx] <= r_tag;
            for (int i = 0; i < WORDS; i++) begin
               data_q[r_idx][OFFSET_W'(i)] <= mem_q[{r_tag, r_idx, OFFSET_W'(i)}];
            end
         end
      end
   end

`ifdef DCACHE_STATS_EN
   logic [15:0] hit_q, miss_q;

   // Saturating read hit/miss counters, classified against the pre-edge tag state.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         hit_q  <= '0;
         miss_q <= '0;
      end else if (r_enable) begin
         if (r_hit && hit_q != 16'hFFFF) begin
            hit_q <= hit_q + 16'd1;
         end else if (!r_hit && miss_q != 16'hFFFF) begin
            miss_q <= miss_q + 16'd1;
         end
      end
   end

   assign hit_count  = hit_q;
   assign miss_count = miss_q;
`endif

endmodule

// File: tb/tb_dcache_direct_mapped.sv
// Scoreboard bench for dcache_direct_mapped: stimulus queues expected read data, a monitor compares.
// Build with DCACHE_STATS_EN defined to also exercise the hit/miss counters.
module tb_dcache_direct_mapped;

   logic        clk = 1'b0;
   logic        rst;
   logic [16:0] r_addr, w_addr;
   logic [31:0] w_data;
   logic        r_enable, w_enable;
   logic [31:0] r_data;
`ifdef DCACHE_STATS_EN
   logic [15:0] hit_count, miss_count;
`endif

   int unsigned n_cmp = 0;
   int unsigned n_err = 0;
   logic [31:0] exp_q[$];
   logic        issued = 1'b0;

   localparam logic [16:0] ADDR_A = 17'b100_1110000000_1011;
   localparam logic [16:0] ADDR_B = 17'b010_1110000000_1011;
   localparam logic [16:0] ADDR_C = 17'b010_1110000000_0000;

   dcache_direct_mapped dut (
      .clk      (clk),
      .rst      (rst),
      .r_addr   (r_addr),
      .w_addr   (w_addr),
      .w_data   (w_data),
      .r_enable (r_enable),
      .w_enable (w_enable),
      .r_data   (r_data)
`ifdef DCACHE_STATS_EN
      ,
      .hit_count  (hit_count),
      .miss_count (miss_count)
`endif
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
      end
   endtask

   // Monitor: a read accepted at a posedge is checked at the following negedge.
   always @(posedge clk) issued <= (r_enable === 1'b1) && (rst === 1'b0);

   always @(negedge clk) begin
      if (issued) begin
         if (exp_q.size() == 0) begin
            n_cmp++;
            n_err++;
            $display("FAIL unexpected_read: got 0x%08h, expected no read", r_data);
         end else begin
            check("read_data", r_data, exp_q.pop_front());
         end
      end
   end

   task automatic op(input logic re, input logic [16:0] ra, input logic we,
                     input logic [16:0] wa, input logic [31:0] wd, input logic [31:0] exp);
      @(negedge clk);
      r_enable = re;
      r_addr   = ra;
      w_enable = we;
      w_addr   = wa;
      w_data   = wd;
      if (re) exp_q.push_back(exp);
   endtask

   task automatic rd(input logic [16:0] ra, input logic [31:0] exp);
      op(1'b1, ra, 1'b0, '0, '0, exp);
   endtask

   task automatic wr(input logic [16:0] wa, input logic [31:0] wd);
      op(1'b0, '0, 1'b1, wa, wd, '0);
   endtask

   task automatic idle();
      op(1'b0, '0, 1'b0, '0, '0, '0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      rst = 1'b1; r_enable = 1'b0; w_enable = 1'b0;
      r_addr = '0; w_addr = '0; w_data = '0;
      repeat (3) @(negedge clk);
      check("reset_rdata", r_data, 32'h0);
      rst = 1'b0;

      rd(ADDR_A, 32'h0);                         // cold miss
      wr(ADDR_A, 32'h00000CCC);
      rd(ADDR_A, 32'h00000CCC);                  // hit after write
      idle();
      idle();
      check("hold_rdata", r_data, 32'h00000CCC);
      rd(ADDR_B, 32'h0);                         // conflict miss evicts A
      rd(ADDR_A, 32'h00000CCC);                  // refetched from backing memory
      rd(ADDR_A, 32'h00000CCC);                  // enable held over two edges
      rd(ADDR_A, 32'h00000CCC);
      op(1'b1, 17'h00005, 1'b1, 17'h00005, 32'hDEADBEEF, 32'hDEADBEEF);
      rd(17'h00005, 32'hDEADBEEF);
      op(1'b1, ADDR_A, 1'b1, ADDR_C, 32'h00000055, 32'h00000CCC);
      rd(ADDR_C, 32'h00000055);
      rd(ADDR_B, 32'h0);                         // rest of the allocated line
      rd(ADDR_A, 32'h00000CCC);
      wr(17'h00023, 32'h000000AB);
      rd(17'h00024, 32'h0);
      rd(17'h00023, 32'h000000AB);

      wr(17'h00010, 32'h12345678);
      idle();
      @(negedge clk);
      rst = 1'b1;
      r_enable = 1'b1;
      r_addr = ADDR_A;
      #1 check("rdata_in_reset", r_data, 32'h0);
      @(negedge clk);
      check("rdata_held_reset", r_data, 32'h0);
      rst = 1'b0;
      r_enable = 1'b0;
      rd(17'h00010, 32'h12345678);
      idle();

`ifdef DCACHE_STATS_EN
      @(negedge clk) rst = 1'b1;
      @(negedge clk) rst = 1'b0;
      rd(17'h00100, 32'h0);
      rd(17'h00100, 32'h0);
      rd(17'h00100, 32'h0);
      rd(17'h04100, 32'h0);
      idle();
      check("hit_count", 32'(hit_count), 32'd2);
      check("miss_count", 32'(miss_count), 32'd2);
      rst = 1'b1;
      #1;
      check("hit_count_rst", 32'(hit_count), 32'd0);
      check("miss_count_rst", 32'(miss_count), 32'd0);
      @(negedge clk) rst = 1'b0;
`endif

      idle();
      idle();
      check("pending_reads", 32'(exp_q.size()), 32'd0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
